// File: rtl/ysyx_22040931_mul_unit_pkg.sv
// Shared definitions for the iterative shift-add multiplier.
package ysyx_22040931_mul_unit_pkg;

  localparam int MUL_XLEN   = 64;
  localparam int MUL_ITER_D = 64;
  localparam int MUL_ITER_W = 32;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/ysyx_22040931_mul_unit_if.sv
// Operand/result handshake between the EX-stage ALU and the multiplier.
interface ysyx_22040931_mul_unit_if
  import ysyx_22040931_mul_unit_pkg::*;
#(
  parameter int XLEN = MUL_XLEN
);

  logic            id_valid;
  logic            ex_ready;
  logic            flush;
  logic            mul_ena;
  logic            mulw;
  logic            mul_signed;
  logic            mul_signor;
  logic [XLEN-1:0] multiplicand;
  logic [XLEN-1:0] multiplier;
  logic            mul_valid;
  logic            mul_ready;
  logic [XLEN-1:0] result_hi;
  logic [XLEN-1:0] result_lo;

  // ALU side: issues operands, consumes the product.
  modport master (
    output id_valid, ex_ready, flush, mul_ena, mulw, mul_signed, mul_signor,
           multiplicand, multiplier,
    input  mul_valid, mul_ready, result_hi, result_lo
  );

  // Multiplier side.
  modport slave (
    input  id_valid, ex_ready, flush, mul_ena, mulw, mul_signed, mul_signor,
           multiplicand, multiplier,
    output mul_valid, mul_ready, result_hi, result_lo
  );

endinterface

// File: rtl/ysyx_22040931_mul_unit.sv
// Iterative shift-add multiplier: one product bit per cycle on operand
// magnitudes, sign fixed up at the end, early-out on a zero operand.
module ysyx_22040931_mul_unit
  import ysyx_22040931_mul_unit_pkg::*;
#(
  parameter int XLEN  = MUL_XLEN,
  parameter int CNT_W = 7
) (
  input  logic                      clock,
  input  logic                      reset,
  ysyx_22040931_mul_unit_if.slave   bus
);

  localparam int HALF = XLEN / 2;

  mul_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [XLEN-1:0]    mcand_q, acc_q, mplier_q;
  logic [XLEN-1:0]    res_hi_q, res_lo_q;
  logic               neg_q, w_q;

  logic [XLEN-1:0]    op_a, op_b, mag_a, mag_b;
  logic               sign_a, sign_b, zero_op, accept, last;
  logic [XLEN:0]      sum;
  logic [2*XLEN-1:0]  shifted, prod, fin;

  // Two's-complement negate when n is set; used for operand magnitudes and
  // for restoring the sign of the product.
  function automatic logic [2*XLEN-1:0] cond_neg(input logic [2*XLEN-1:0] v,
                                                 input logic n);
    return n ? (~v + {{(2*XLEN-1){1'b0}}, 1'b1}) : v;
  endfunction

  // Operand extension, magnitude and early-out detection at accept.
  always_comb begin
    op_a = bus.mulw ? (bus.mul_signed ?
             {{HALF{bus.multiplicand[HALF-1]}}, bus.multiplicand[HALF-1:0]} :
             {{HALF{1'b0}}, bus.multiplicand[HALF-1:0]}) : bus.multiplicand;
    op_b = bus.mulw ? (bus.mul_signor ?
             {{HALF{bus.multiplier[HALF-1]}}, bus.multiplier[HALF-1:0]} :
             {{HALF{1'b0}}, bus.multiplier[HALF-1:0]}) : bus.multiplier;
    sign_a  = bus.mul_signed & op_a[XLEN-1];
    sign_b  = bus.mul_signor & op_b[XLEN-1];
    mag_a   = XLEN'(cond_neg({{XLEN{1'b0}}, op_a}, sign_a));
    mag_b   = XLEN'(cond_neg({{XLEN{1'b0}}, op_b}, sign_b));
    zero_op = (mag_a == '0) | (mag_b == '0);
    accept  = bus.id_valid & bus.mul_ena & (state_q == MUL_IDLE) & ~bus.flush;
  end

  // One add-and-shift step plus final sign correction. For word ops only 32
  // steps run, so the product sits 32 bits higher in the shift register.
  always_comb begin
    sum     = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    shifted = {sum, mplier_q[XLEN-1:1]};
    prod    = w_q ? (shifted >> HALF) : shifted;
    fin     = cond_neg(prod, neg_q);
    last    = cnt_q == (w_q ? CNT_W'(MUL_ITER_W - 1) : CNT_W'(MUL_ITER_D - 1));
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= MUL_IDLE;
    else        state_q <= state_d;
  end

  // Next state and handshake outputs; flush overrides everything.
  always_comb begin
    state_d       = state_q;
    bus.mul_ready = 1'b0;
    bus.mul_valid = 1'b0;
    case (state_q)
      MUL_IDLE: begin
        bus.mul_ready = 1'b1;
        if (accept) state_d = zero_op ? MUL_DONE : MUL_BUSY;
      end
      MUL_BUSY: if (last) state_d = MUL_DONE;
      MUL_DONE: begin
        bus.mul_valid = 1'b1;
        if (bus.ex_ready) state_d = MUL_IDLE;
      end
      default:  state_d = MUL_IDLE;
    endcase
    if (bus.flush) state_d = MUL_IDLE;
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      w_q      <= 1'b0;
      res_hi_q <= '0;
      res_lo_q <= '0;
    end else if (accept) begin
      cnt_q    <= '0;
      mcand_q  <= mag_a;
      mplier_q <= mag_b;
      acc_q    <= '0;
      neg_q    <= sign_a ^ sign_b;
      w_q      <= bus.mulw;
      if (zero_op) begin
        res_hi_q <= '0;
        res_lo_q <= '0;
      end
    end else if (state_q == MUL_BUSY && !bus.flush) begin
      acc_q    <= sum[XLEN:1];
      mplier_q <= {sum[0], mplier_q[XLEN-1:1]};
      cnt_q    <= cnt_q + CNT_W'(1);
      if (last) begin
        res_hi_q <= w_q ? '0 : fin[2*XLEN-1:XLEN];
        res_lo_q <= w_q ? {{HALF{fin[HALF-1]}}, fin[HALF-1:0]} : fin[XLEN-1:0];
      end
    end
  end

  assign bus.result_hi = res_hi_q;
  assign bus.result_lo = res_lo_q;

endmodule
